// File: rtl/aoi_stim_sequencer.sv
// Exhaustive stimulus sequencer for a four-input AOI gate: sweeps {a,b,c,d} through 0..15 and captures e.
// Define AOI_CHECK_EN to build in the response checker (err / err_cnt ports).
module aoi_stim_sequencer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned LOOPS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       e,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       sample_valid,
  output logic       sample_e,
  output logic [3:0] sample_vec
`ifdef AOI_CHECK_EN
  ,
  output logic       err,
  output logic [4:0] err_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] LOOP_LAST  = 4'(LOOPS - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] dwell_q, dwell_d;
  logic [3:0] loop_q, loop_d;
  logic       sample_valid_q;
  logic       sample_e_q;
  logic [3:0] sample_vec_q;
  logic       capture;
  logic       run_start;

  assign run_start = (state_q == S_IDLE) && start && !abort;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    loop_d  = loop_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_start) begin
          state_d = S_RUN;
          idx_d   = 4'd0;
          dwell_d = 8'd0;
          loop_d  = 4'd0;
        end
      end
      S_RUN: begin
        if (abort) begin
          // The partial dwell is dropped: no capture, no done.
          state_d = S_IDLE;
          idx_d   = 4'd0;
          dwell_d = 8'd0;
          loop_d  = 4'd0;
        end else if (dwell_q == DWELL_LAST) begin
          capture = 1'b1;
          dwell_d = 8'd0;
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'hF) begin
            loop_d = loop_q + 4'd1;
            if (loop_q == LOOP_LAST) begin
              state_d = S_DONE;
              loop_d  = 4'd0;
            end
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= 4'd0;
      dwell_q        <= 8'd0;
      loop_q         <= 4'd0;
      sample_valid_q <= 1'b0;
      sample_e_q     <= 1'b0;
      sample_vec_q   <= 4'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      dwell_q        <= dwell_d;
      loop_q         <= loop_d;
      sample_valid_q <= capture;
      if (capture) begin
        sample_e_q   <= e;
        sample_vec_q <= idx_q;
      end
    end
  end

`ifdef AOI_CHECK_EN
  logic       err_q;
  logic [4:0] err_cnt_q;
  logic       expected_e;

  assign expected_e = ~((idx_q[3] & idx_q[2]) | (idx_q[1] & idx_q[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= 5'd0;
    end else if (run_start) begin
      err_q     <= 1'b0;
      err_cnt_q <= 5'd0;
    end else if (capture && (e != expected_e)) begin
      err_q <= 1'b1;
      if (err_cnt_q != 5'd31) err_cnt_q <= err_cnt_q + 5'd1;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

  // idx_q is held at zero outside RUN, so it drives the stimulus directly from a register.
  assign {a, b, c, d}  = idx_q;
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign sample_valid = sample_valid_q;
  assign sample_e     = sample_e_q;
  assign sample_vec   = sample_vec_q;

endmodule

// File: tb/tb_aoi_stim_sequencer.sv
// Randomised self-checking bench: two sequencer instances (DWELL=4/LOOPS=1 and DWELL=1/LOOPS=2)
// against a cycle-count based model, plus literal expectations for the reference scenarios.
`timescale 1ns/1ps
module tb_aoi_stim_sequencer;

  localparam int DW0 = 4;
  localparam int LP0 = 1;
  localparam int DW1 = 1;
  localparam int LP1 = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tie1  = 1'b0;
  logic [15:0] mask  = 16'h0000;

  logic a0, b0, c0, d0, busy0, done0, sv0, se0, e0;
  logic a1, b1, c1, d1, busy1, done1, sv1, se1, e1;
  logic [3:0] svec0, svec1;
`ifdef AOI_CHECK_EN
  logic err0, err1;
  logic [4:0] cnt0, cnt1;
`endif

  always #5 clk = ~clk;

  function automatic logic aoi(input logic [3:0] v);
    return ~((v[3] & v[2]) | (v[1] & v[0]));
  endfunction

  // Downstream gate: correct AOI, optionally corrupted per vector by mask, or tied high.
  assign e0 = tie1 ? 1'b1 : (aoi({a0, b0, c0, d0}) ^ mask[{a0, b0, c0, d0}]);
  assign e1 = tie1 ? 1'b1 : (aoi({a1, b1, c1, d1}) ^ mask[{a1, b1, c1, d1}]);

  aoi_stim_sequencer #(.DWELL(DW0), .LOOPS(LP0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .e(e0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
    .sample_valid(sv0), .sample_e(se0), .sample_vec(svec0)
`ifdef AOI_CHECK_EN
    , .err(err0), .err_cnt(cnt0)
`endif
  );

  aoi_stim_sequencer #(.DWELL(DW1), .LOOPS(LP1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .e(e1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .sample_valid(sv1), .sample_e(se1), .sample_vec(svec1)
`ifdef AOI_CHECK_EN
    , .err(err1), .err_cnt(cnt1)
`endif
  );

  logic [3:0] dv[2];
  logic [3:0] dsvec[2];
  logic       dbusy[2], ddone[2], dsv[2], dse[2];
  assign dv[0] = {a0, b0, c0, d0};
  assign dv[1] = {a1, b1, c1, d1};
  assign dsvec[0] = svec0;
  assign dsvec[1] = svec1;
  assign dbusy[0] = busy0;
  assign dbusy[1] = busy1;
  assign ddone[0] = done0;
  assign ddone[1] = done1;
  assign dsv[0] = sv0;
  assign dsv[1] = sv1;
  assign dse[0] = se0;
  assign dse[1] = se1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dw(input int i);
    return (i == 0) ? DW0 : DW1;
  endfunction

  function automatic int lp(input int i);
    return (i == 0) ? LP0 : LP1;
  endfunction

  // Model: phase 0 idle, 1 run, 2 done; m_t counts RUN cycles elapsed; outputs follow from m_t.
  int         m_ph[2], m_t[2], m_cnt[2];
  logic       m_sv[2], m_se[2], m_done[2], m_err[2];
  logic [3:0] m_svec[2];

  int          n_busy[2], n_sv[2], n_done[2], streak[2], max_streak[2];
  logic [15:0] pk_se[2];

  task automatic model_reset(input int i);
    m_ph[i] = 0; m_t[i] = 0; m_cnt[i] = 0;
    m_sv[i] = 1'b0; m_se[i] = 1'b0; m_done[i] = 1'b0; m_err[i] = 1'b0;
    m_svec[i] = 4'd0;
  endtask

  // Advance the model across the coming rising edge, using the inputs that edge will sample.
  task automatic model_step(input int i);
    int         total;
    logic [3:0] v;
    logic       ev;
    total     = 16 * dw(i) * lp(i);
    m_sv[i]   = 1'b0;
    m_done[i] = 1'b0;
    case (m_ph[i])
      0: if (start && !abort) begin
        m_ph[i] = 1; m_t[i] = 0; m_err[i] = 1'b0; m_cnt[i] = 0;
      end
      1: if (abort) begin
        m_ph[i] = 0; m_t[i] = 0;
      end else begin
        v = 4'((m_t[i] / dw(i)) % 16);
        if ((m_t[i] % dw(i)) == dw(i) - 1) begin
          ev = tie1 ? 1'b1 : (aoi(v) ^ mask[v]);
          m_sv[i] = 1'b1; m_se[i] = ev; m_svec[i] = v;
          if (ev != aoi(v)) begin
            m_err[i] = 1'b1;
            if (m_cnt[i] < 31) m_cnt[i]++;
          end
        end
        m_t[i]++;
        if (m_t[i] == total) begin
          m_ph[i] = 2; m_done[i] = 1'b1;
        end
      end
      default: m_ph[i] = 0;
    endcase
  endtask

  task automatic compare(input int i);
    logic [3:0] ev;
    ev = (m_ph[i] == 1) ? 4'((m_t[i] / dw(i)) % 16) : 4'd0;
    check($sformatf("abcd[%0d]", i), dv[i], ev);
    check($sformatf("busy[%0d]", i), dbusy[i], m_ph[i] == 1);
    check($sformatf("done[%0d]", i), ddone[i], m_done[i]);
    check($sformatf("sample_valid[%0d]", i), dsv[i], m_sv[i]);
    check($sformatf("sample_e[%0d]", i), dse[i], m_se[i]);
    check($sformatf("sample_vec[%0d]", i), dsvec[i], m_svec[i]);
`ifdef AOI_CHECK_EN
    check($sformatf("err[%0d]", i), (i == 0) ? err0 : err1, m_err[i]);
    check($sformatf("err_cnt[%0d]", i), (i == 0) ? cnt0 : cnt1, m_cnt[i]);
`endif
  endtask

  // Single compare process: checks on falling clock edges, resets the model on reset.
  initial begin
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      n_busy[i] = 0; n_sv[i] = 0; n_done[i] = 0; streak[i] = 0; max_streak[i] = 0;
      pk_se[i] = 16'h0000;
    end
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          model_reset(i);
          if (!clk) compare(i);
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          compare(i);
          if (dbusy[i]) n_busy[i]++;
          if (ddone[i]) n_done[i]++;
          if (dsv[i]) begin
            n_sv[i]++;
            pk_se[i][dsvec[i]] = dse[i];
            streak[i]++;
            if (streak[i] > max_streak[i]) max_streak[i] = streak[i];
          end else begin
            streak[i] = 0;
          end
          model_step(i);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done0(input int budget);
    int k;
    k = 0;
    while (!done0 && k < budget) begin
      cyc(1);
      k++;
    end
    check("done0_within_budget", done0, 1'b1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_busy, s_sv, s_done, s_sv1, s_done1;

    #6 rst_n = 1'b0;
    #1;
    check("rst_abcd0", dv[0], 4'd0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_sv0", sv0, 1'b0);
    check("rst_svec1", svec1, 4'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(2);

    // Reference run with a correct gate.
    s_busy = n_busy[0]; s_sv = n_sv[0]; s_done = n_done[0];
    s_sv1 = n_sv[1]; s_done1 = n_done[1];
    pulse_start();
    wait_done0(200);
    cyc(2);
    check("runA_busy_cycles", n_busy[0] - s_busy, 64);
    check("runA_sample_count", n_sv[0] - s_sv, 16);
    check("runA_done_count", n_done[0] - s_done, 1);
    check("runA_sample_e_packed", pk_se[0], 16'h0777);
    check("dw1_sample_count", n_sv[1] - s_sv1, 32);
    check("dw1_max_streak", max_streak[1], 32);
    check("dw1_done_count", n_done[1] - s_done1, 1);
`ifdef AOI_CHECK_EN
    check("runA_err", err0, 1'b0);
`endif

    // e stuck high: seven vectors should mismatch per sweep.
    tie1 = 1'b1;
    pulse_start();
    wait_done0(200);
`ifdef AOI_CHECK_EN
    check("tie1_err", err0, 1'b1);
    check("tie1_err_cnt", cnt0, 5'd7);
    check("tie1_err_cnt_dw1", cnt1, 5'd14);
`endif
    cyc(2);
    tie1 = 1'b0;

    // Every capture mismatches: the two-loop instance saturates its counter.
    mask = 16'hFFFF;
    pulse_start();
    wait_done0(200);
`ifdef AOI_CHECK_EN
    check("all_bad_err_cnt", cnt0, 5'd16);
    check("saturate_err_cnt", cnt1, 5'd31);
`endif
    cyc(2);
    mask = 16'h0000;

    // Abort during RUN cycle 20 (cycle 0 is the first RUN cycle).
    s_sv = n_sv[0]; s_done = n_done[0];
    pulse_start();
    cyc(20);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("abort_busy", busy0, 1'b0);
    check("abort_abcd", dv[0], 4'd0);
    cyc(3);
    check("abort_sample_count", n_sv[0] - s_sv, 5);
    check("abort_no_done", n_done[0] - s_done, 0);

    // start and abort together in IDLE.
    start = 1'b1; abort = 1'b1;
    cyc(5);
    check("start_abort_idle0", busy0, 1'b0);
    check("start_abort_idle1", busy1, 1'b0);
    start = 1'b0; abort = 1'b0;
    cyc(1);

    // Asynchronous reset in the middle of a dwell.
    pulse_start();
    cyc(10);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy0, 1'b0);
    check("async_rst_abcd", dv[0], 4'd0);
    check("async_rst_sv", sv1, 1'b0);
    check("async_rst_svec", dsvec[0], 4'd0);
    #1 rst_n = 1'b1;
    s_busy = n_busy[0]; s_sv = n_sv[1];
    cyc(10);
    check("post_rst_idle_busy", n_busy[0] - s_busy, 0);
    check("post_rst_idle_sv", n_sv[1] - s_sv, 0);

    // start held high: no restart until DONE has passed.
    s_done = n_done[0];
    start = 1'b1;
    wait_done0(200);
    check("hold_start_done_count", n_done[0] - s_done + 1, 1);
    cyc(1);
    check("hold_start_idle_gap", busy0, 1'b0);
    cyc(1);
    check("hold_start_restart", busy0, 1'b1);
    abort = 1'b1;
    start = 1'b0;
    cyc(1);
    abort = 1'b0;
    cyc(2);

    // Randomised traffic; the compare process checks every cycle.
    mask = 16'($urandom);
    for (int k = 0; k < 3000; k++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 63) == 0);
      if (!busy0 && !busy1 && $urandom_range(0, 3) == 0) mask = 16'($urandom);
      if ($urandom_range(0, 499) == 0) tie1 = ~tie1;
      cyc(1);
    end
    start = 1'b0; abort = 1'b0;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aoi_stim_sequencer.md
AOI_STIM_SEQUENCER -- requirements
Module: aoi_stim_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, giving clock cycles each input vector is held (legal range 1..255).
REQ-002 The block SHALL have parameter LOOPS, default 1, giving full 16-vector sweeps per run (legal range 1..15).
REQ-003 The block SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  level; sampled in IDLE only; begins a run.
REQ-007 abort  input  1  level; terminates a run.
REQ-008 e  input  1  output of the downstream four-input AOI gate.
REQ-009 a, b, c, d  output  1 each  registered gate stimulus.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse on normal completion.
REQ-012 sample_valid  output  1  one-cycle pulse; sample_e and sample_vec are valid.
REQ-013 sample_e  output  1  captured value of e.
REQ-014 sample_vec  output  4  {a,b,c,d} vector that produced sample_e.
REQ-015 With AOI_CHECK_EN defined: err  output  1  sticky mismatch flag; err_cnt  output  5  mismatch count.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE->RUN SHALL occur on the rising edge where start=1 and abort=0; abort SHALL win when both are high.
REQ-018 On entry to RUN, the vector index SHALL be 0, the dwell counter 0 and the loop counter 0.
REQ-019 {a,b,c,d} SHALL equal the 4-bit vector index, with a as MSB, throughout RUN.
REQ-020 {a,b,c,d} SHALL be 0 in IDLE and DONE.
REQ-021 The dwell counter SHALL increment every RUN cycle.
REQ-022 At the edge where the dwell counter equals DWELL-1, e SHALL be captured into sample_e and the current index into sample_vec.
REQ-023 sample_valid SHALL be 1 for exactly the following cycle.
REQ-024 At the same edge, the dwell counter SHALL clear and the index SHALL increment modulo 16.
REQ-025 At the same edge, index wrap from 15 to 0 SHALL increment the loop counter.
REQ-026 When capturing index 15 on loop LOOPS-1, the FSM SHALL go to DONE.
REQ-027 DONE SHALL last one cycle with done=1 (coincident with the final sample_valid), then return to IDLE.
REQ-028 busy SHALL be high for exactly 16*DWELL*LOOPS cycles per completed run.
REQ-029 start while in RUN or DONE SHALL be ignored.
REQ-030 abort=1 in RUN SHALL force IDLE at the next edge with {a,b,c,d}=0 and busy=0, with no done pulse and no sample_valid for the partial dwell.
REQ-031 With DWELL=1, a sample SHALL occur every RUN cycle.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE regardless of clk, including mid-run.
REQ-033 During reset, a,b,c,d, busy, done, sample_valid, sample_e, sample_vec, err and err_cnt SHALL all be 0, and all counters SHALL be cleared.
REQ-034 After rst_n deassertion, no run SHALL begin without a new start.

Configuration
REQ-035 Macro AOI_CHECK_EN SHALL compile in the response checker; when it is undefined, err and err_cnt SHALL not exist and no checker logic is present.
REQ-036 With AOI_CHECK_EN defined, each capture SHALL compare e against the expected value ~((a&b)|(c&d)) of the current vector.
REQ-037 With AOI_CHECK_EN defined, a mismatch SHALL set err (sticky) and increment err_cnt, saturating at 31.
REQ-038 With AOI_CHECK_EN defined, err and err_cnt SHALL clear on the IDLE->RUN transition.

Verification
REQ-039 DWELL=4, LOOPS=1, correct AOI model, single start -> busy high for 64 cycles; 16 sample_valid pulses with sample_vec 0..15; sample_e bit-packed by index = 16'h0777; done one pulse; err=0.
REQ-040 Same run, e tied to 1 -> err=1, err_cnt=7 at done.
REQ-041 abort asserted on RUN cycle 20 -> busy=0 and abcd=0 next cycle; exactly 5 sample_valid pulses seen; no done.
REQ-042 rst_n pulsed low mid-dwell (asynchronous to clk) -> all outputs 0 immediately; no activity until the next start.
REQ-043 start held high throughout a run -> no restart until after DONE; start and abort high together in IDLE -> stays IDLE.
REQ-044 DWELL=1, LOOPS=2 -> 32 consecutive sample_valid cycles; sample_vec 0..15 twice; done after cycle 32.
